// File: rtl/if_id_pipe_pkg.sv
// Shared constants and types for the IF/ID pipeline register and its skid buffer.
// Stall/reset levels mirror the legacy defines header (Stop, RstEnable, ZeroWord).
package if_id_pipe_pkg;

  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam int          DEF_PC_W   = 32;
  localparam int          DEF_INST_W = 32;

  typedef enum logic [1:0] {
    OP_FLUSH   = 2'd0,
    OP_ADVANCE = 2'd1,
    OP_BUBBLE  = 2'd2,
    OP_HOLD    = 2'd3
  } pipe_op_e;

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

  // Flush outranks any stall; the downstream stall bit only matters while this stage stops.
  function automatic pipe_op_e decode_op(input logic flush, input logic s, input logic d);
    pipe_op_e op;
    if (flush) begin
      op = OP_FLUSH;
    end else if (s == NO_STOP) begin
      op = OP_ADVANCE;
    end else if (d == NO_STOP) begin
      op = OP_BUBBLE;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/if_id_skid.sv
// One-entry lane-bundle skid buffer: captures a fetch response arriving while
// the stage is stopped and releases it on the next advance.
module if_id_skid
  import if_id_pipe_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int PC_W   = DEF_PC_W,
  parameter int INST_W = DEF_INST_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  pipe_op_e                i_op,
  input  logic                    i_present,
  input  logic [LANES-1:0]        i_valid,
  input  logic [LANES*PC_W-1:0]   i_pc,
  input  logic [LANES*INST_W-1:0] i_inst,
  output logic                    o_full,
  output logic [LANES-1:0]        o_valid,
  output logic [LANES*PC_W-1:0]   o_pc,
  output logic [LANES*INST_W-1:0] o_inst,
  output logic                    o_ovf
);

  skid_state_e             r_state;
  skid_state_e             w_state_nxt;
  logic                    w_load;
  logic                    w_ovf;
  logic                    r_ovf;
  logic [LANES-1:0]        r_valid;
  logic [LANES*PC_W-1:0]   r_pc;
  logic [LANES*INST_W-1:0] r_inst;

  // Skid state register plus registered overflow pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state <= SKID_EMPTY;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf;
    end
  end

  // Next-state: an advance drains the entry and may refill it with the incoming bundle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovf       = 1'b0;
    case (i_op)
      OP_FLUSH: begin
        w_state_nxt = SKID_EMPTY;
      end
      OP_ADVANCE: begin
        if ((r_state == SKID_FULL) && i_present) begin
          w_load      = 1'b1;
          w_state_nxt = SKID_FULL;
        end else begin
          w_state_nxt = SKID_EMPTY;
        end
      end
      OP_BUBBLE, OP_HOLD: begin
        if (i_present && (r_state == SKID_EMPTY)) begin
          w_load      = 1'b1;
          w_state_nxt = SKID_FULL;
        end else if (i_present) begin
          w_ovf = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = SKID_EMPTY;
      end
    endcase
  end

  // Entry payload; only overwritten on a capture so an overflow keeps the older bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_valid <= '0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else begin
      r_valid <= r_valid;
      r_pc    <= r_pc;
      r_inst  <= r_inst;
    end
  end

  assign o_full  = (r_state == SKID_FULL);
  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/if_id_pipe.sv
// Multi-lane IF/ID pipeline register with stall/flush handling and a 1-entry skid.
// Optional performance counters are built when IF_ID_PERF_EN is defined.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int PC_W    = DEF_PC_W,
  parameter int INST_W  = DEF_INST_W,
  parameter int STALL_W = 6,
  parameter int STAGE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        if_valid,
  input  logic [LANES*PC_W-1:0]   if_pc,
  input  logic [LANES*INST_W-1:0] if_inst,
  output logic [LANES-1:0]        id_valid,
  output logic [LANES*PC_W-1:0]   id_pc,
  output logic [LANES*INST_W-1:0] id_inst,
  output logic                    skid_full,
  output logic                    skid_ovf,
  output logic [31:0]             bubble_cnt,
  output logic [31:0]             hold_cnt
);

  pipe_op_e                w_op;
  logic                    w_present;
  logic                    w_unused_stall;
  logic [LANES*PC_W-1:0]   w_in_pc;
  logic [LANES*INST_W-1:0] w_in_inst;
  logic                    w_skid_full;
  logic [LANES-1:0]        w_skid_valid;
  logic [LANES*PC_W-1:0]   w_skid_pc;
  logic [LANES*INST_W-1:0] w_skid_inst;
  logic [LANES-1:0]        r_valid;
  logic [LANES*PC_W-1:0]   r_pc;
  logic [LANES*INST_W-1:0] r_inst;

  assign w_op           = decode_op(flush, stall[STAGE] == STOP, stall[STAGE+1] == STOP);
  assign w_present      = |if_valid;
  assign w_unused_stall = ^stall;

  // Invalid lanes carry zero pc/inst so downstream never sees stale fetch data.
  always_comb begin
    w_in_pc   = '0;
    w_in_inst = '0;
    for (int i = 0; i < LANES; i++) begin
      if (if_valid[i]) begin
        w_in_pc[i*PC_W +: PC_W]       = if_pc[i*PC_W +: PC_W];
        w_in_inst[i*INST_W +: INST_W] = if_inst[i*INST_W +: INST_W];
      end else begin
        w_in_pc[i*PC_W +: PC_W]       = '0;
        w_in_inst[i*INST_W +: INST_W] = '0;
      end
    end
  end

  if_id_skid #(
    .LANES  (LANES),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_op      (w_op),
    .i_present (w_present),
    .i_valid   (if_valid),
    .i_pc      (w_in_pc),
    .i_inst    (w_in_inst),
    .o_full    (w_skid_full),
    .o_valid   (w_skid_valid),
    .o_pc      (w_skid_pc),
    .o_inst    (w_skid_inst),
    .o_ovf     (skid_ovf)
  );

  // Decode-side register: the skid entry wins over the direct path to keep program order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_valid <= '0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else begin
      case (w_op)
        OP_ADVANCE: begin
          if (w_skid_full) begin
            r_valid <= w_skid_valid;
            r_pc    <= w_skid_pc;
            r_inst  <= w_skid_inst;
          end else begin
            r_valid <= if_valid;
            r_pc    <= w_in_pc;
            r_inst  <= w_in_inst;
          end
        end
        OP_HOLD: begin
          r_valid <= r_valid;
          r_pc    <= r_pc;
          r_inst  <= r_inst;
        end
        default: begin
          r_valid <= '0;
          r_pc    <= '0;
          r_inst  <= '0;
        end
      endcase
    end
  end

  assign id_valid  = r_valid;
  assign id_pc     = r_pc;
  assign id_inst   = r_inst;
  assign skid_full = w_skid_full;

`ifdef IF_ID_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_hold_cnt;

  // Free-running wrap-around counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      r_bubble_cnt <= ZERO_WORD;
      r_hold_cnt   <= ZERO_WORD;
    end else begin
      r_bubble_cnt <= (w_op == OP_BUBBLE) ? r_bubble_cnt + 32'd1 : r_bubble_cnt;
      r_hold_cnt   <= (w_op == OP_HOLD)   ? r_hold_cnt + 32'd1   : r_hold_cnt;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign hold_cnt   = r_hold_cnt;
`else
  assign bubble_cnt = ZERO_WORD;
  assign hold_cnt   = ZERO_WORD;
`endif

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
Parametrised fetch/decode pipeline register, the next generation of the single-lane IF/ID latch.
- Carries LANES parallel {pc, inst, valid} slots, so the same block serves single- and dual-issue front ends.
- Honours the shared 6-bit stall vector and a flush request.
- Contains a 1-entry skid buffer that catches a fetch response landing during a stall (synchronous instruction memory has 1-cycle latency), so no instruction is lost or refetched.
- Sits between the fetch stage / inst ROM and the decode stage.

Parameters:
LANES, 1, number of parallel issue slots (1..4)
PC_W, 32, width of each pc field
INST_W, 32, width of each instruction field
STALL_W, 6, width of stall vector
STAGE, 1, index of this stage in the stall vector; stall[STAGE+1] is the downstream stage (requires STAGE+1 < STALL_W)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
stall  in  STALL_W  pipeline stall vector, bit=1 means Stop
flush  in  1  discard all in-flight fetch data
if_valid  in  LANES  per-lane fetch response valid
if_pc  in  LANES*PC_W  lane i at [i*PC_W +: PC_W]
if_inst  in  LANES*INST_W  lane i at [i*INST_W +: INST_W]
id_valid  out  LANES  per-lane decode valid
id_pc  out  LANES*PC_W  decode pc bundle
id_inst  out  LANES*INST_W  decode inst bundle
skid_full  out  1  skid buffer occupied
skid_ovf  out  1  one-cycle pulse: fetch data dropped because skid already full
bubble_cnt  out  32  bubble cycles inserted (see Optional Feature)
hold_cnt  out  32  hold cycles (see Optional Feature)

Behaviour:
- Reset, asynchronous on rst=0:
  - id_valid=0, id_pc=0, id_inst=0.
  - skid EMPTY, skid_ovf=0, counters=0.
- Decode per cycle: S=stall[STAGE], D=stall[STAGE+1]. Priority per edge is reset > flush > bubble/hold/advance.
- Any lane "present": |if_valid. The skid stores the whole lane bundle (valid, pc and inst for all lanes) as one entry.
- flush=1:
  - Outputs cleared (valid=0, pc=0, inst=0); skid -> EMPTY.
  - Incoming fetch data in the same cycle is discarded.
- ADVANCE (S=0):
  - Skid FULL: outputs <= skid entry. Skid <= incoming bundle if present (stays FULL), else EMPTY.
  - Skid EMPTY: outputs <= incoming bundle. Lanes with if_valid=0 load valid=0, pc=0, inst=0.
- BUBBLE (S=1, D=0):
  - Outputs <= zero with valid=0 (NOP injected downstream).
  - Incoming bundle present and skid EMPTY -> captured, skid FULL.
- HOLD (S=1, D=1):
  - Outputs unchanged.
  - Skid capture rule as in BUBBLE.
- Overflow: bundle present while S=1 and skid already FULL -> bundle dropped, skid keeps the older entry, skid_ovf=1 for that cycle only. Upstream is required never to cause this; it is a checker hook.
- Latency:
  - 1 cycle from if_* to id_* when the skid is EMPTY.
  - 2 cycles when draining through the skid.
- Skid state machine: EMPTY <-> FULL only; skid_full is the registered state.
- Order guarantee: a skid entry always reaches the outputs before any younger bundle.

Optional Feature:
Macro IF_ID_PERF_EN.
- Defined: bubble_cnt increments on every BUBBLE cycle (flush not active); hold_cnt increments on every HOLD cycle. Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared only by reset.
- Not defined: no counter flops; bubble_cnt and hold_cnt are tied to 0. The port list is identical either way.

Decomposition:
- Shared defines header (the existing defines.h) supplies Stop/NoStop, RstEnable-style reset level for active-low, ZeroWord, and the default PC and instruction widths.
- One natural sub-module: if_id_skid, the 1-entry bundle buffer with capture/drain/ovf logic. The top instantiates it once and muxes its output against the direct path.

Test Plan:
- Reset mid-stream: drive if_valid=1, pc=0x100, release/assert rst=0 asynchronously between edges -> id_valid=0, id_pc=0, skid_full=0 immediately, without waiting for a clock edge.
- Straight flow, LANES=2: pcs 0x0/0x4, then 0x8/0xC on consecutive cycles, stall=0 -> id_pc shows each pair exactly 1 cycle later, id_valid=2'b11.
- Hold with skid: stall=6'b000110 while pc 0x20 arrives -> outputs hold previous, skid_full=1. Release stall with pc 0x24 arriving -> id_pc=0x20, next cycle 0x24, no loss.
- Bubble: stall=6'b000010 for one cycle -> id_valid=0, id_inst=0 next cycle; with PERF enabled, bubble_cnt=1.
- Flush with skid full: skid holds 0x40, flush=1 with pc 0x44 arriving -> outputs zero, skid_full=0, neither 0x40 nor 0x44 ever appears.
- Overflow: hold two cycles with if_valid=1 (pcs 0x50, 0x54) -> skid keeps 0x50, skid_ovf pulses on the second cycle only.
